// File: rtl/bg_scene_sequencer.sv
// bg_scene_sequencer: picks the active background, scrolls it per frame, and blanks between scene switches
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   vsync_i            vsync level from the timing generator
//   auto_en_i          advance to the next scene after DWELL_FRAMES frames
//   speed_i            scroll increment per frame
//   req_valid_i/req_bg_i/req_ready_o  host scene-change request handshake
//   bg_sel_o, bg_en_o  current scene index and its one-hot enable (zero while blanked)
//   scroll_x_o         horizontal scroll offset
//   blank_out_o        forces video black during a transition
//   frame_cnt_o        free-running frame counter
module bg_scene_sequencer #(
  parameter int NUM_BG       = 4,
  parameter int DWELL_FRAMES = 256,
  parameter int FADE_FRAMES  = 4,
  parameter int SCROLL_W     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync_i,
  input  logic                auto_en_i,
  input  logic [2:0]          speed_i,
  input  logic                req_valid_i,
  input  logic [1:0]          req_bg_i,
  output logic                req_ready_o,
  output logic [1:0]          bg_sel_o,
  output logic [NUM_BG-1:0]   bg_en_o,
  output logic [SCROLL_W-1:0] scroll_x_o,
  output logic                blank_out_o,
  output logic [15:0]         frame_cnt_o
);
  typedef enum logic [1:0] {SHOW, BLANK, SWITCH} state_e;
  localparam logic [15:0]       DWELL_LAST = 16'(DWELL_FRAMES - 1);
  localparam logic [7:0]        FADE_LAST  = 8'(FADE_FRAMES - 1);
  localparam logic [1:0]        LAST_BG    = 2'(NUM_BG - 1);
  localparam logic [NUM_BG-1:0] ONE        = NUM_BG'(1);
  state_e              state_q, state_d;
  logic                vsync_q;
  logic [15:0]         dwell_q, dwell_d;
  logic [7:0]          fade_q, fade_d;
  logic [1:0]          target_q, target_d;
  logic [1:0]          bg_sel_q, bg_sel_d;
  logic [NUM_BG-1:0]   bg_en_q, bg_en_d;
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  logic                blank_q, blank_d;
  logic [15:0]         frame_q, frame_d;
  logic                tick, accept, req_useful, expire;
  logic [1:0]          next_bg;
  assign tick        = vsync_i & ~vsync_q;
  assign accept      = req_valid_i & (state_q == SHOW);
  // a request for the current scene or a nonexistent one is consumed without effect
  assign req_useful  = (req_bg_i != bg_sel_q) && ({1'b0, req_bg_i} < 3'(NUM_BG));
  assign expire      = auto_en_i & tick & (dwell_q == DWELL_LAST);
  assign next_bg     = (bg_sel_q == LAST_BG) ? 2'd0 : bg_sel_q + 2'd1;
  assign req_ready_o = state_q == SHOW;
  assign bg_sel_o    = bg_sel_q;
  assign bg_en_o     = bg_en_q;
  assign scroll_x_o  = scroll_q;
  assign blank_out_o = blank_q;
  assign frame_cnt_o = frame_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SHOW;
      vsync_q  <= 1'b0;
      dwell_q  <= '0;
      fade_q   <= '0;
      target_q <= '0;
      bg_sel_q <= '0;
      bg_en_q  <= ONE;
      scroll_q <= '0;
      blank_q  <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync_i;
      dwell_q  <= dwell_d;
      fade_q   <= fade_d;
      target_q <= target_d;
      bg_sel_q <= bg_sel_d;
      bg_en_q  <= bg_en_d;
      scroll_q <= scroll_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
    end
  end
  // an accepted request decides alone; dwell expiry only counts when no request is taken
  always_comb begin
    state_d = state_q;
    if (state_q == SHOW && (accept ? req_useful : expire)) state_d = BLANK;
    else if (state_q == BLANK && tick && fade_q == FADE_LAST) state_d = SWITCH;
    else if (state_q == SWITCH) state_d = SHOW;
  end
  always_comb begin
    frame_d  = frame_q + 16'(tick);
    target_d = (state_q == SHOW && state_d == BLANK) ? (accept ? req_bg_i : next_bg) : target_q;
    dwell_d  = (state_q == SWITCH) ? '0 :
               (state_q == SHOW && tick && dwell_q != DWELL_LAST) ? dwell_q + 16'd1 : dwell_q;
    fade_d   = (state_q == BLANK) ? fade_q + 8'(tick) : '0;
    scroll_d = (state_q == SWITCH) ? '0 :
               (state_q == SHOW && tick) ? scroll_q + SCROLL_W'(speed_i) : scroll_q;
    bg_sel_d = (state_q == SWITCH) ? target_q : bg_sel_q;
    blank_d  = state_d != SHOW;
    bg_en_d  = blank_d ? '0 : ONE << bg_sel_d;
  end
endmodule

// File: tb/tb_bg_scene_sequencer.sv
// tb_bg_scene_sequencer: directed and random stimulus against a frame-level scene model
module tb_bg_scene_sequencer;
  localparam int NB = 3, DW = 4, FD = 2, SW = 6;
  logic clk = 0, rst = 1, vsync = 0, auto_en = 0, req_valid = 0;
  logic [2:0] speed = 0;
  logic [1:0] req_bg = 0;
  logic req_ready, blank_out;
  logic [1:0] bg_sel;
  logic [NB-1:0] bg_en;
  logic [SW-1:0] scroll_x;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0;
  int m_scene, m_target, m_scroll, m_frames, m_dwell, m_fade_left;
  bit m_switch, m_vs_prev;

  bg_scene_sequencer #(.NUM_BG(NB), .DWELL_FRAMES(DW), .FADE_FRAMES(FD), .SCROLL_W(SW)) dut (
    .clk(clk), .rst(rst), .vsync_i(vsync), .auto_en_i(auto_en), .speed_i(speed),
    .req_valid_i(req_valid), .req_bg_i(req_bg), .req_ready_o(req_ready), .bg_sel_o(bg_sel),
    .bg_en_o(bg_en), .scroll_x_o(scroll_x), .blank_out_o(blank_out), .frame_cnt_o(frame_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // scene model: a countdown of blanked frames, then one switch cycle, then the new scene
  task automatic step_model();
    bit tick, blanked, expiry;
    if (rst) begin
      m_scene = 0; m_target = 0; m_scroll = 0; m_frames = 0; m_dwell = 0;
      m_fade_left = 0; m_switch = 0; m_vs_prev = 0;
      return;
    end
    tick = vsync && !m_vs_prev;
    m_vs_prev = vsync;
    if (tick) m_frames = (m_frames + 1) % 65536;
    blanked = m_switch || m_fade_left > 0;
    if (m_switch) begin
      m_scene = m_target; m_scroll = 0; m_dwell = 0; m_switch = 0;
    end else if (blanked) begin
      if (tick) begin
        m_fade_left--;
        if (m_fade_left == 0) m_switch = 1;
      end
    end else begin
      expiry = 0;
      if (tick) begin
        m_scroll = (m_scroll + speed) % (1 << SW);
        expiry = auto_en && m_dwell == DW - 1;
        if (m_dwell < DW - 1) m_dwell++;
      end
      if (req_valid) begin
        if (req_bg != m_scene && req_bg < NB) begin
          m_target = req_bg; m_fade_left = FD;
        end
      end else if (expiry) begin
        m_target = (m_scene + 1) % NB; m_fade_left = FD;
      end
    end
  endtask

  task automatic cyc();
    bit blk;
    @(posedge clk);
    step_model();
    #1;
    blk = m_switch || m_fade_left > 0;
    chk("bg_sel", 32'(bg_sel), 32'(m_scene));
    chk("bg_en", 32'(bg_en), blk ? 32'd0 : 32'(1 << m_scene));
    chk("blank_out", 32'(blank_out), 32'(blk));
    chk("scroll_x", 32'(scroll_x), 32'(m_scroll));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("req_ready", 32'(req_ready), 32'(!blk));
  endtask

  task automatic pulse();
    vsync = 1; cyc();
    vsync = 0; cyc();
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_bg_en", 32'(bg_en), 32'b001);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst = 0; speed = 5;
    repeat (3) pulse();
    chk("lit_scroll15", 32'(scroll_x), 32'd15);
    chk("lit_frames3", 32'(frame_cnt), 32'd3);
    chk("lit_bg_en001", 32'(bg_en), 32'b001);
    chk("lit_ready1", 32'(req_ready), 32'd1);
    auto_en = 1; pulse();
    chk("lit_auto_blank", 32'(blank_out), 32'd1);
    chk("lit_auto_en0", 32'(bg_en), 32'd0);
    repeat (2) pulse();
    chk("lit_auto_sel1", 32'(bg_sel), 32'd1);
    chk("lit_auto_en010", 32'(bg_en), 32'b010);
    chk("lit_auto_scroll0", 32'(scroll_x), 32'd0);
    auto_en = 0; req_valid = 1; req_bg = 2; cyc();
    chk("lit_req_blank", 32'(blank_out), 32'd1);
    chk("lit_req_ready0", 32'(req_ready), 32'd0);
    repeat (2) pulse();
    chk("lit_req_sel2", 32'(bg_sel), 32'd2);
    cyc();
    chk("lit_same_noblank", 32'(blank_out), 32'd0);
    req_bg = 3; cyc();
    chk("lit_bad_noblank", 32'(blank_out), 32'd0);
    chk("lit_bad_sel", 32'(bg_sel), 32'd2);
    req_bg = 0; cyc(); req_valid = 0;
    repeat (2) pulse();
    chk("lit_back_sel0", 32'(bg_sel), 32'd0);
    repeat (3) pulse();
    auto_en = 1; vsync = 1; req_valid = 1; req_bg = 2; cyc();
    req_valid = 0; vsync = 0; cyc();
    repeat (2) pulse();
    chk("lit_race_sel2", 32'(bg_sel), 32'd2);
    auto_en = 0; req_valid = 1; req_bg = 1; cyc(); req_valid = 0;
    pulse();
    chk("lit_mid_blank", 32'(blank_out), 32'd1);
    rst = 1; cyc();
    chk("lit_rst_sel0", 32'(bg_sel), 32'd0);
    chk("lit_rst_en001", 32'(bg_en), 32'b001);
    chk("lit_rst_blank0", 32'(blank_out), 32'd0);
    chk("lit_rst_frames0", 32'(frame_cnt), 32'd0);
    rst = 0; vsync = 1;
    repeat (100) cyc();
    chk("lit_held_frames1", 32'(frame_cnt), 32'd1);
    vsync = 0; cyc();
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      auto_en = $urandom_range(0, 7) != 0;
      speed = 3'($urandom_range(0, 7));
      req_valid = $urandom_range(0, 9) == 0;
      req_bg = 2'($urandom_range(0, 3));
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
